// File: rtl/multicycle_fsm_pkg.sv
// Shared types and encodings for the multicycle control FSM.
// Opcodes, state names and datapath select codes live here.
package multicycle_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Where DECODE goes for a given opcode.
  function automatic state_t decode_route(
    input logic [6:0] op
  );
    state_t s;
    case (op)
      OP_LW:   s = S_MEMADR;
      OP_SW:   s = S_MEMADR;
      OP_R:    s = S_EXECR;
      OP_I:    s = S_EXECI;
      OP_JAL:  s = S_JAL;
      OP_BEQ:  s = S_BEQ;
      default: s = S_FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_fsm_imm_deco.sv
// Immediate-format select, decoded from the opcode alone.
// Purely combinational so it tracks op in every state.
module imm_deco
  import multicycle_fsm_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] immSrc
);

  // Map opcode to immediate format.
  always_comb begin
    immSrc = IMM_I;
    case (op)
      OP_SW:   immSrc = IMM_S;
      OP_BEQ:  immSrc = IMM_B;
      OP_JAL:  immSrc = IMM_J;
      default: immSrc = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_fsm.sv
// Control FSM for a multicycle RISC-V datapath.
// Moore state machine; FETCH strobes follow memReady.
module multicycle_fsm
  import multicycle_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       memReady,
  output logic       PCUpdate,
  output logic       branch,
  output logic       IRWrite,
  output logic       regWrite,
  output logic       memWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] immSrc,
  output logic [3:0] state
);

  state_t state_q;

  imm_deco u_imm_deco (
    .op     (op),
    .immSrc (immSrc)
  );

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:
          if (memReady) state_q <= S_DECODE;
        S_DECODE:
          state_q <= decode_route(op);
        S_MEMADR:
          state_q <= (op == OP_SW) ? S_MEMWRITE
                                   : S_MEMREAD;
        S_MEMREAD:
          if (memReady) state_q <= S_MEMWB;
        S_MEMWRITE:
          if (memReady) state_q <= S_FETCH;
        S_EXECR:  state_q <= S_ALUWB;
        S_EXECI:  state_q <= S_ALUWB;
        S_JAL:    state_q <= S_ALUWB;
        S_MEMWB:  state_q <= S_FETCH;
        S_ALUWB:  state_q <= S_FETCH;
        S_BEQ:    state_q <= S_FETCH;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  assign state = state_q;

  // Decode datapath controls from the current state.
  always_comb begin
    PCUpdate  = 1'b0;
    branch    = 1'b0;
    IRWrite   = 1'b0;
    regWrite  = 1'b0;
    memWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ResultSrc = RES_ALUOUT;
    ALUOp     = ALU_ADD;
    if (reset) begin
      ALUSrcB   = SRCB_4;
      ResultSrc = RES_ALU;
    end else begin
      case (state_q)
        S_FETCH: begin
          ALUSrcB   = SRCB_4;
          ResultSrc = RES_ALU;
          IRWrite   = memReady;
          PCUpdate  = memReady;
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEMREAD: begin
          AdrSrc = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = RES_MEM;
          regWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          memWrite = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALU_FUNCT;
        end
        S_EXECI: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALU_FUNCT;
        end
        S_ALUWB: begin
          regWrite = 1'b1;
        end
        S_JAL: begin
          ALUSrcA  = SRCA_OLDPC;
          ALUSrcB  = SRCB_4;
          PCUpdate = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALU_SUB;
          branch  = 1'b1;
        end
        default: begin
          ALUSrcB   = SRCB_4;
          ResultSrc = RES_ALU;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_fsm.sv
// Scenario bench for multicycle_fsm.
// Expected per-cycle results are queued, then popped and compared.
module tb_multicycle_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       memReady;
  logic       PCUpdate, branch, IRWrite;
  logic       regWrite, memWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [1:0] ALUOp, immSrc;
  logic [3:0] state;

  int checks = 0;
  int passes = 0;

  // we = {PCUpdate, branch, IRWrite, regWrite, memWrite}
  typedef struct {
    logic       rst;
    logic       mr;
    logic [6:0] op;
    logic [3:0] st;
    logic [4:0] we;
    logic [1:0] alu;
  } ent_t;

  ent_t sb[$];

  multicycle_fsm dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .memReady  (memReady),
    .PCUpdate  (PCUpdate),
    .branch    (branch),
    .IRWrite   (IRWrite),
    .regWrite  (regWrite),
    .memWrite  (memWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .immSrc    (immSrc),
    .state     (state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  function automatic logic [1:0] imm_of(
    input logic [6:0] o
  );
    case (o)
      SW:      return 2'b01;
      BQ:      return 2'b10;
      JL:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic ent_t mk(
    input logic       rst,
    input logic       mr,
    input logic [6:0] o,
    input logic [3:0] st,
    input logic [4:0] we,
    input logic [1:0] alu
  );
    ent_t e;
    e.rst = rst; e.mr = mr; e.op = o;
    e.st = st; e.we = we; e.alu = alu;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1; memReady = 1'b1; op = LW;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (state !== 4'd0)
      $display("FAIL rst_state got %0d want 0", state);
    else passes++;
    checks++;
    if ({PCUpdate, branch, IRWrite, regWrite, memWrite} !== 5'b0)
      $display("FAIL rst_we got %b want 00000",
        {PCUpdate, branch, IRWrite, regWrite, memWrite});
    else passes++;
    checks++;
    if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp} !== 9'b0_00_10_10_00)
      $display("FAIL rst_mux got %b want 000101000",
        {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp});
    else passes++;
  endtask

  task automatic test_lw();
    int n = 0;
    logic [12:0] got, want;
    sb.push_back(mk(0, 1, LW, 0, 5'b10100, 2'b00));
    sb.push_back(mk(0, 1, LW, 1, 5'b00000, 2'b00));
    sb.push_back(mk(0, 1, LW, 2, 5'b00000, 2'b00));
    sb.push_back(mk(0, 1, LW, 3, 5'b00000, 2'b00));
    sb.push_back(mk(0, 1, LW, 4, 5'b00010, 2'b00));
    sb.push_back(mk(0, 0, LW, 0, 5'b00000, 2'b00));
    while (sb.size() > 0) begin
      ent_t e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; memReady = e.mr; op = e.op;
      #1;
      got = {state, PCUpdate, branch, IRWrite,
             regWrite, memWrite, ALUOp, immSrc};
      want = {e.st, e.we, e.alu, imm_of(e.op)};
      checks++;
      if (got !== want)
        $display("FAIL lw[%0d] got %b want %b", n, got, want);
      else passes++;
      if (e.st == 4'd3) begin
        checks++;
        if (AdrSrc !== 1'b1)
          $display("FAIL lw_adrsrc got %b want 1", AdrSrc);
        else passes++;
      end
      n++;
    end
  endtask

  task automatic test_sw_wait();
    int n = 0;
    logic [12:0] got, want;
    sb.push_back(mk(0, 1, SW, 0, 5'b10100, 2'b00));
    sb.push_back(mk(0, 1, SW, 1, 5'b00000, 2'b00));
    sb.push_back(mk(0, 1, SW, 2, 5'b00000, 2'b00));
    sb.push_back(mk(0, 0, SW, 5, 5'b00001, 2'b00));
    sb.push_back(mk(0, 0, SW, 5, 5'b00001, 2'b00));
    sb.push_back(mk(0, 1, SW, 5, 5'b00001, 2'b00));
    sb.push_back(mk(0, 0, SW, 0, 5'b00000, 2'b00));
    while (sb.size() > 0) begin
      ent_t e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; memReady = e.mr; op = e.op;
      #1;
      got = {state, PCUpdate, branch, IRWrite,
             regWrite, memWrite, ALUOp, immSrc};
      want = {e.st, e.we, e.alu, imm_of(e.op)};
      checks++;
      if (got !== want)
        $display("FAIL sw[%0d] got %b want %b", n, got, want);
      else passes++;
      n++;
    end
  endtask

  task automatic test_beq();
    int n = 0;
    logic [12:0] got, want;
    sb.push_back(mk(0, 1, BQ, 0, 5'b10100, 2'b00));
    sb.push_back(mk(0, 1, BQ, 1, 5'b00000, 2'b00));
    sb.push_back(mk(0, 1, BQ, 10, 5'b01000, 2'b01));
    sb.push_back(mk(0, 0, BQ, 0, 5'b00000, 2'b00));
    while (sb.size() > 0) begin
      ent_t e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; memReady = e.mr; op = e.op;
      #1;
      got = {state, PCUpdate, branch, IRWrite,
             regWrite, memWrite, ALUOp, immSrc};
      want = {e.st, e.we, e.alu, imm_of(e.op)};
      checks++;
      if (got !== want)
        $display("FAIL beq[%0d] got %b want %b", n, got, want);
      else passes++;
      n++;
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [12:0] got, want;
    sb.push_back(mk(0, 1, RT, 0, 5'b10100, 2'b00));
    sb.push_back(mk(0, 1, RT, 1, 5'b00000, 2'b00));
    sb.push_back(mk(0, 1, RT, 6, 5'b00000, 2'b10));
    sb.push_back(mk(0, 1, RT, 7, 5'b00010, 2'b00));
    sb.push_back(mk(0, 1, JL, 0, 5'b10100, 2'b00));
    sb.push_back(mk(0, 1, JL, 1, 5'b00000, 2'b00));
    sb.push_back(mk(0, 1, JL, 9, 5'b10000, 2'b00));
    sb.push_back(mk(0, 1, JL, 7, 5'b00010, 2'b00));
    sb.push_back(mk(0, 0, JL, 0, 5'b00000, 2'b00));
    while (sb.size() > 0) begin
      ent_t e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; memReady = e.mr; op = e.op;
      #1;
      got = {state, PCUpdate, branch, IRWrite,
             regWrite, memWrite, ALUOp, immSrc};
      want = {e.st, e.we, e.alu, imm_of(e.op)};
      checks++;
      if (got !== want)
        $display("FAIL b2b[%0d] got %b want %b", n, got, want);
      else passes++;
      n++;
    end
  endtask

  task automatic test_unknown();
    int n = 0;
    logic [12:0] got, want;
    sb.push_back(mk(0, 1, BAD, 0, 5'b10100, 2'b00));
    sb.push_back(mk(0, 1, BAD, 1, 5'b00000, 2'b00));
    sb.push_back(mk(0, 0, BAD, 0, 5'b00000, 2'b00));
    sb.push_back(mk(0, 0, BAD, 0, 5'b00000, 2'b00));
    sb.push_back(mk(0, 1, BAD, 0, 5'b10100, 2'b00));
    sb.push_back(mk(0, 1, BAD, 1, 5'b00000, 2'b00));
    sb.push_back(mk(0, 0, BAD, 0, 5'b00000, 2'b00));
    while (sb.size() > 0) begin
      ent_t e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; memReady = e.mr; op = e.op;
      #1;
      got = {state, PCUpdate, branch, IRWrite,
             regWrite, memWrite, ALUOp, immSrc};
      want = {e.st, e.we, e.alu, imm_of(e.op)};
      checks++;
      if (got !== want)
        $display("FAIL unk[%0d] got %b want %b", n, got, want);
      else passes++;
      n++;
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic [12:0] got, want;
    sb.push_back(mk(0, 1, LW, 0, 5'b10100, 2'b00));
    sb.push_back(mk(0, 1, LW, 1, 5'b00000, 2'b00));
    sb.push_back(mk(0, 1, LW, 2, 5'b00000, 2'b00));
    sb.push_back(mk(1, 1, LW, 3, 5'b00000, 2'b00));
    sb.push_back(mk(1, 1, LW, 0, 5'b00000, 2'b00));
    sb.push_back(mk(0, 1, LW, 0, 5'b10100, 2'b00));
    sb.push_back(mk(0, 1, LW, 1, 5'b00000, 2'b00));
    while (sb.size() > 0) begin
      ent_t e = sb.pop_front();
      @(negedge clk);
      reset = e.rst; memReady = e.mr; op = e.op;
      #1;
      got = {state, PCUpdate, branch, IRWrite,
             regWrite, memWrite, ALUOp, immSrc};
      want = {e.st, e.we, e.alu, imm_of(e.op)};
      checks++;
      if (got !== want)
        $display("FAIL rstmid[%0d] got %b want %b", n, got, want);
      else passes++;
      n++;
    end
  endtask

  initial begin
    reset = 1'b1;
    op = 7'd0;
    memReady = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_back_to_back();
    test_unknown();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
